// File: rtl/iserdes_bitslip_ctrl.sv
// Word-alignment trainer for one ISERDESE2 lane (1:8 DDR) in the divclk domain.
// Issues spaced BITSLIP pulses until q holds the training pattern, then reports locked or fail.
`timescale 1ns/1ps

module iserdes_bitslip_ctrl #(
  parameter int              DW            = 8,
  parameter logic [DW-1:0]   TRAIN_PATTERN = 8'hFA,
  parameter int              SETTLE_CYCLES = 3,
  parameter int              MATCH_COUNT   = 16,
  parameter int              MAX_SLIPS     = 8
) (
  input  logic                             divclk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DW-1:0]                    q,
  output logic                             bitslip,
  output logic                             busy,
  output logic                             locked,
  output logic                             fail,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);
  localparam int MCW = $clog2(MATCH_COUNT + 1);
  localparam int STW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [STW-1:0] SETTLE_LOAD = STW'(SETTLE_CYCLES);
  localparam logic [STW-1:0] SETTLE_ONE  = STW'(1);
  localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
  localparam logic [MCW-1:0] MATCH_ONE   = MCW'(1);
  localparam logic [SCW-1:0] SLIP_MAX    = SCW'(MAX_SLIPS);
  localparam logic [SCW-1:0] SLIP_ONE    = SCW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t           state, state_n;
  logic [STW-1:0]   settle_cnt, settle_n;
  logic [MCW-1:0]   match_cnt, match_n;
  logic [SCW-1:0]   slip_cnt, slip_n;

  // slip_cnt advances on entry to SLIP so it rises together with the bitslip pulse
  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    match_n  = match_cnt;
    slip_n   = slip_cnt;
    case (state)
      S_IDLE, S_LOCKED, S_FAIL: begin
        if (start) begin
          state_n  = S_SETTLE;
          settle_n = SETTLE_LOAD;
          match_n  = '0;
          slip_n   = '0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt <= SETTLE_ONE) begin
          state_n  = S_CHECK;
          settle_n = '0;
          match_n  = '0;
        end else begin
          settle_n = settle_cnt - SETTLE_ONE;
        end
      end
      S_CHECK: begin
        if (q == TRAIN_PATTERN) begin
          match_n = match_cnt + MATCH_ONE;
          if (match_cnt >= MATCH_LAST) state_n = S_LOCKED;
        end else if (slip_cnt < SLIP_MAX) begin
          state_n = S_SLIP;
          match_n = '0;
          slip_n  = slip_cnt + SLIP_ONE;
        end else begin
          state_n = S_FAIL;
        end
      end
      S_SLIP: begin
        state_n  = S_SETTLE;
        settle_n = SETTLE_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are flopped from the next-state decode so they align with the state register
  always_ff @(posedge divclk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      match_cnt  <= match_n;
      slip_cnt   <= slip_n;
      bitslip    <= (state_n == S_SLIP);
      busy       <= (state_n == S_SETTLE) || (state_n == S_CHECK) || (state_n == S_SLIP);
      locked     <= (state_n == S_LOCKED);
      fail       <= (state_n == S_FAIL);
    end
  end

  assign slip_count = slip_cnt;

endmodule

// File: tb/tb_iserdes_bitslip_ctrl.sv
// Directed bench for iserdes_bitslip_ctrl with a small ISERDES model that rotates
// the delivered word by one bit two cycles after each bitslip pulse.
`timescale 1ns/1ps

module tb_iserdes_bitslip_ctrl;

  localparam logic [7:0] PAT = 8'hFA;

  logic       divclk;
  logic       reset;
  logic       start;
  logic [7:0] q;
  logic       bitslip;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [3:0] slip_count;

  int checks = 0;
  int passed = 0;

  logic [2:0] need = 3'd0;
  logic       slip_d1 = 1'b0;
  logic       model_load = 1'b0;
  logic [2:0] model_load_val = 3'd0;
  logic       q_zero = 1'b0;
  logic       glitch = 1'b0;

  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  bit have_last = 1'b0;
  int spacing_viol = 0;
  int excl_viol = 0;

  iserdes_bitslip_ctrl dut (
    .divclk     (divclk),
    .reset      (reset),
    .start      (start),
    .q          (q),
    .bitslip    (bitslip),
    .busy       (busy),
    .locked     (locked),
    .fail       (fail),
    .slip_count (slip_count)
  );

  initial begin
    divclk = 1'b0;
    forever #5 divclk = ~divclk;
  end

  function automatic logic [7:0] rot8(input logic [7:0] x, input logic [2:0] n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < 8; i++)
      if (i < int'(n)) y = {y[6:0], y[7]};
    return y;
  endfunction

  // ISERDES model: need = number of slips still required to reach alignment
  always @(posedge divclk) begin
    slip_d1 <= (bitslip === 1'b1);
    if (model_load) need <= model_load_val;
    else if (slip_d1) need <= need - 3'd1;
  end

  assign q = q_zero ? 8'h00 : (rot8(PAT, need) ^ {8{glitch}});

  // Observe just after each edge: pulse count, pulse spacing, output exclusivity
  always @(posedge divclk) begin
    #3;
    cyc++;
    if (bitslip === 1'b1) begin
      pulses++;
      if (have_last && (cyc - last_pulse_cyc) < 5) spacing_viol++;
      have_last = 1'b1;
      last_pulse_cyc = cyc;
    end
    if ((locked === 1'b1 && fail === 1'b1) ||
        (busy === 1'b1 && (locked === 1'b1 || fail === 1'b1)))
      excl_viol++;
  end

  task automatic set_model(input logic [2:0] n);
    @(negedge divclk);
    model_load_val = n;
    model_load = 1'b1;
    @(negedge divclk);
    model_load = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle 1 (start sampled at the end of cycle 0)
  task automatic start_pulse();
    @(negedge divclk);
    start = 1'b1;
    @(negedge divclk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge divclk);
    checks++; if (bitslip !== 1'b0) $display("[TB] FAIL rst_bitslip: got %b expected 0", bitslip); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL rst_locked: got %b expected 0", locked); else passed++;
    checks++; if (fail !== 1'b0) $display("[TB] FAIL rst_fail: got %b expected 0", fail); else passed++;
    checks++; if (slip_count !== 4'd0) $display("[TB] FAIL rst_slip_count: got %0d expected 0", slip_count); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_aligned();
    int p0;
    set_model(3'd0);
    p0 = pulses;
    start_pulse();
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t1_busy_c1: got %b expected 1", busy); else passed++;
    repeat (18) @(negedge divclk);
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t1_locked_c19: got %b expected 0", locked); else passed++;
    @(negedge divclk);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL t1_locked_c20: got %b expected 1", locked); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t1_busy_c20: got %b expected 0", busy); else passed++;
    checks++; if (slip_count !== 4'd0) $display("[TB] FAIL t1_slip_count: got %0d expected 0", slip_count); else passed++;
    checks++; if (pulses - p0 !== 0) $display("[TB] FAIL t1_pulses: got %0d expected 0", pulses - p0); else passed++;
  endtask

  task automatic test_offset3();
    int p0;
    int n;
    set_model(3'd3);
    p0 = pulses;
    start_pulse();
    n = 0;
    while (locked !== 1'b1 && n < 300) begin
      @(negedge divclk);
      n++;
    end
    checks++; if (locked !== 1'b1) $display("[TB] FAIL t2_lock_timeout: locked=%b after %0d cycles", locked, n); else passed++;
    checks++; if (1 + n !== 35) $display("[TB] FAIL t2_lock_cycle: got %0d expected 35", 1 + n); else passed++;
    checks++; if (pulses - p0 !== 3) $display("[TB] FAIL t2_pulses: got %0d expected 3", pulses - p0); else passed++;
    checks++; if (slip_count !== 4'd3) $display("[TB] FAIL t2_slip_count: got %0d expected 3", slip_count); else passed++;
    checks++; if (spacing_viol !== 0) $display("[TB] FAIL t2_spacing: got %0d close pulses expected 0", spacing_viol); else passed++;
  endtask

  task automatic test_never_aligns();
    int p0;
    int n;
    q_zero = 1'b1;
    p0 = pulses;
    start_pulse();
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t3_locked_drop: got %b expected 0", locked); else passed++;
    n = 0;
    while (fail !== 1'b1 && n < 300) begin
      @(negedge divclk);
      n++;
    end
    checks++; if (fail !== 1'b1) $display("[TB] FAIL t3_fail_timeout: fail=%b after %0d cycles", fail, n); else passed++;
    checks++; if (1 + n !== 45) $display("[TB] FAIL t3_fail_cycle: got %0d expected 45", 1 + n); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t3_busy: got %b expected 0", busy); else passed++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t3_locked: got %b expected 0", locked); else passed++;
    checks++; if (slip_count !== 4'd8) $display("[TB] FAIL t3_slip_count: got %0d expected 8", slip_count); else passed++;
    repeat (20) @(negedge divclk);
    checks++; if (pulses - p0 !== 8) $display("[TB] FAIL t3_pulses: got %0d expected 8", pulses - p0); else passed++;
    checks++; if (fail !== 1'b1) $display("[TB] FAIL t3_fail_hold: got %b expected 1", fail); else passed++;
    q_zero = 1'b0;
  endtask

  task automatic test_glitch();
    int p0;
    int n;
    set_model(3'd0);
    p0 = pulses;
    start_pulse();
    checks++; if (fail !== 1'b0) $display("[TB] FAIL t4_fail_drop: got %b expected 0", fail); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t4_busy_c1: got %b expected 1", busy); else passed++;
    repeat (12) @(negedge divclk);
    glitch = 1'b1;
    @(negedge divclk);
    glitch = 1'b0;
    checks++; if (bitslip !== 1'b1) $display("[TB] FAIL t4_slip_c14: got %b expected 1", bitslip); else passed++;
    checks++; if (slip_count !== 4'd1) $display("[TB] FAIL t4_slip_count_c14: got %0d expected 1", slip_count); else passed++;
    n = 0;
    while (locked !== 1'b1 && n < 400) begin
      @(negedge divclk);
      n++;
    end
    checks++; if (locked !== 1'b1) $display("[TB] FAIL t4_lock_timeout: locked=%b after %0d cycles", locked, n); else passed++;
    checks++; if (14 + n !== 69) $display("[TB] FAIL t4_lock_cycle: got %0d expected 69", 14 + n); else passed++;
    checks++; if (pulses - p0 !== 8) $display("[TB] FAIL t4_pulses: got %0d expected 8", pulses - p0); else passed++;
    checks++; if (slip_count !== 4'd8) $display("[TB] FAIL t4_slip_count: got %0d expected 8", slip_count); else passed++;
  endtask

  task automatic test_retrain();
    int p0;
    set_model(3'd0);
    p0 = pulses;
    start_pulse();
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t6_locked_c1: got %b expected 0", locked); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t6_busy_c1: got %b expected 1", busy); else passed++;
    checks++; if (slip_count !== 4'd0) $display("[TB] FAIL t6_slip_count_c1: got %0d expected 0", slip_count); else passed++;
    repeat (18) @(negedge divclk);
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t6_locked_c19: got %b expected 0", locked); else passed++;
    @(negedge divclk);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL t6_locked_c20: got %b expected 1", locked); else passed++;
    checks++; if (pulses - p0 !== 0) $display("[TB] FAIL t6_pulses: got %0d expected 0", pulses - p0); else passed++;
  endtask

  task automatic test_reset_in_slip();
    set_model(3'd1);
    start_pulse();
    repeat (4) @(negedge divclk);
    checks++; if (bitslip !== 1'b1) $display("[TB] FAIL t5_slip_c5: got %b expected 1", bitslip); else passed++;
    reset = 1'b1;
    @(negedge divclk);
    checks++; if (bitslip !== 1'b0) $display("[TB] FAIL t5_bitslip_after_rst: got %b expected 0", bitslip); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t5_busy_after_rst: got %b expected 0", busy); else passed++;
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t5_locked_after_rst: got %b expected 0", locked); else passed++;
    checks++; if (fail !== 1'b0) $display("[TB] FAIL t5_fail_after_rst: got %b expected 0", fail); else passed++;
    checks++; if (slip_count !== 4'd0) $display("[TB] FAIL t5_slip_count_after_rst: got %0d expected 0", slip_count); else passed++;
    reset = 1'b0;
    set_model(3'd0);
    start_pulse();
    @(negedge divclk);
    start = 1'b1;
    @(negedge divclk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t5_busy_c3: got %b expected 1", busy); else passed++;
    repeat (16) @(negedge divclk);
    checks++; if (locked !== 1'b0) $display("[TB] FAIL t5_locked_c19: got %b expected 0", locked); else passed++;
    @(negedge divclk);
    checks++; if (locked !== 1'b1) $display("[TB] FAIL t5_locked_c20: got %b expected 1", locked); else passed++;
    checks++; if (slip_count !== 4'd0) $display("[TB] FAIL t5_slip_count: got %0d expected 0", slip_count); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    $display("[TB] starting iserdes_bitslip_ctrl bench");
    test_reset();
    test_aligned();
    test_offset3();
    test_never_aligns();
    test_glitch();
    test_retrain();
    test_reset_in_slip();
    checks++; if (spacing_viol !== 0) $display("[TB] FAIL pulse_spacing: got %0d close pulses expected 0", spacing_viol); else passed++;
    checks++; if (excl_viol !== 0) $display("[TB] FAIL output_exclusive: got %0d violations expected 0", excl_viol); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
